// File: rtl/ila_capture_ctrl.sv
// Capture controller feeding the ILA sample FIFO write port.
// Holds a pre-trigger delay line, evaluates a masked level/edge trigger and pushes a bounded sample window.
module ila_capture_ctrl #(
  parameter int DATA_W    = 40,
  parameter int TRIG_W    = 8,
  parameter int PRE_DEPTH = 4,
  parameter int CNT_W     = 15
) (
  input  logic              wclk,
  input  logic              rst,
  input  logic              arm_i,
  input  logic              abort_i,
  input  logic              force_trig_i,
  input  logic              sample_en_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [TRIG_W-1:0] trig_i,
  input  logic [TRIG_W-1:0] trig_pattern_i,
  input  logic [TRIG_W-1:0] trig_mask_i,
  input  logic              trig_edge_i,
  input  logic [CNT_W-1:0]  capture_len_i,
  input  logic              fifo_full_i,
  output logic              PUSH_o,
  output logic [DATA_W-1:0] DI_o,
  output logic              busy_o,
  output logic              triggered_o,
  output logic              done_o,
  output logic              overflow_o,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int FILL_W = $clog2(PRE_DEPTH + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PRE_DEPTH);

  state_t              state_reg;
  logic [FILL_W-1:0]   fill_reg;
  logic                match_prev_reg;
  logic [CNT_W:0]      push_cnt_reg;
  logic [CNT_W:0]      target_reg;
  logic                triggered_reg;
  logic                overflow_reg;
  logic                push_reg;
  logic [DATA_W-1:0]   di_reg;
  logic [DATA_W-1:0]   delay_reg [PRE_DEPTH];

  logic [TRIG_W-1:0]   bit_ok;
  logic                match;
  logic                trig_hit;
  logic [CNT_W:0]      target_next;
  logic [CNT_W:0]      push_cnt_next;
  logic                shift_en;

  // A bit either is masked out or must equal its pattern bit.
  for (genvar gi = 0; gi < TRIG_W; gi++) begin : g_match
    assign bit_ok[gi] = ~trig_mask_i[gi] | (trig_i[gi] == trig_pattern_i[gi]);
  end

  assign match         = &bit_ok;
  assign trig_hit      = sample_en_i && (fill_reg == FILL_MAX) &&
                         (force_trig_i || (trig_edge_i ? (match && !match_prev_reg) : match));
  assign target_next   = (CNT_W+1)'(PRE_DEPTH + 1) + {1'b0, capture_len_i};
  assign push_cnt_next = push_cnt_reg + (CNT_W+1)'(1);
  assign shift_en      = sample_en_i && (state_reg != ST_IDLE);

  // Pushes take the outgoing tail sample, so the window starts PRE_DEPTH samples before the trigger.
  always_ff @(posedge wclk) begin
    if (!rst) begin
      for (int i = 0; i < PRE_DEPTH; i++) delay_reg[i] <= '0;
    end else if (shift_en) begin
      delay_reg[0] <= data_i;
      for (int i = 1; i < PRE_DEPTH; i++) delay_reg[i] <= delay_reg[i-1];
    end
  end

  always_ff @(posedge wclk) begin
    if (!rst) begin
      state_reg      <= ST_IDLE;
      fill_reg       <= '0;
      match_prev_reg <= 1'b0;
      push_cnt_reg   <= '0;
      target_reg     <= '0;
      triggered_reg  <= 1'b0;
      overflow_reg   <= 1'b0;
      push_reg       <= 1'b0;
      di_reg         <= '0;
    end else begin
      push_reg <= 1'b0;
      if (abort_i) begin
        state_reg <= ST_IDLE;
      end else begin
        case (state_reg)
          ST_IDLE, ST_DONE: begin
            if (arm_i) begin
              state_reg      <= ST_ARMED;
              fill_reg       <= '0;
              match_prev_reg <= 1'b0;
              triggered_reg  <= 1'b0;
              overflow_reg   <= 1'b0;
              push_cnt_reg   <= '0;
            end
          end
          ST_ARMED: begin
            if (sample_en_i) begin
              if (fill_reg != FILL_MAX) fill_reg <= fill_reg + FILL_W'(1);
              match_prev_reg <= match;
              if (trig_hit) begin
                triggered_reg <= 1'b1;
                target_reg    <= target_next;
                if (fifo_full_i) begin
                  overflow_reg <= 1'b1;
                  state_reg    <= ST_DONE;
                end else begin
                  push_reg     <= 1'b1;
                  di_reg       <= delay_reg[PRE_DEPTH-1];
                  push_cnt_reg <= (CNT_W+1)'(1);
                  state_reg    <= ST_CAPTURE;
                end
              end
            end
          end
          ST_CAPTURE: begin
            if (sample_en_i) begin
              if (fifo_full_i) begin
                overflow_reg <= 1'b1;
                state_reg    <= ST_DONE;
              end else begin
                push_reg     <= 1'b1;
                di_reg       <= delay_reg[PRE_DEPTH-1];
                push_cnt_reg <= push_cnt_next;
                if (push_cnt_next == target_reg) state_reg <= ST_DONE;
              end
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign PUSH_o      = push_reg;
  assign DI_o        = di_reg;
  assign triggered_o = triggered_reg;
  assign overflow_o  = overflow_reg;
  assign state_o     = state_reg;
  assign busy_o      = (state_reg == ST_ARMED) || (state_reg == ST_CAPTURE);
  assign done_o      = (state_reg == ST_DONE);

endmodule

// File: tb/tb_ila_capture_ctrl.sv
// Bench for ila_capture_ctrl: sample-history reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ila_capture_ctrl;
  localparam int DATA_W    = 40;
  localparam int TRIG_W    = 8;
  localparam int PRE_DEPTH = 4;
  localparam int CNT_W     = 15;

  logic              wclk = 1'b0;
  logic              rst = 1'b0;
  logic              arm_i = 1'b0, abort_i = 1'b0, force_trig_i = 1'b0, sample_en_i = 1'b0;
  logic [DATA_W-1:0] data_i = '0;
  logic [TRIG_W-1:0] trig_i = '0, trig_pattern_i = '0, trig_mask_i = '0;
  logic              trig_edge_i = 1'b0;
  logic [CNT_W-1:0]  capture_len_i = '0;
  logic              fifo_full_i = 1'b0;
  logic              PUSH_o;
  logic [DATA_W-1:0] DI_o;
  logic              busy_o, triggered_o, done_o, overflow_o;
  logic [1:0]        state_o;

  always #5 wclk = ~wclk;

  ila_capture_ctrl #(.DATA_W(DATA_W), .TRIG_W(TRIG_W), .PRE_DEPTH(PRE_DEPTH), .CNT_W(CNT_W)) dut (
    .wclk(wclk), .rst(rst), .arm_i(arm_i), .abort_i(abort_i), .force_trig_i(force_trig_i),
    .sample_en_i(sample_en_i), .data_i(data_i), .trig_i(trig_i), .trig_pattern_i(trig_pattern_i),
    .trig_mask_i(trig_mask_i), .trig_edge_i(trig_edge_i), .capture_len_i(capture_len_i),
    .fifo_full_i(fifo_full_i), .PUSH_o(PUSH_o), .DI_o(DI_o), .busy_o(busy_o),
    .triggered_o(triggered_o), .done_o(done_o), .overflow_o(overflow_o), .state_o(state_o)
  );

  int n_cmp = 0;
  int n_mis = 0;
  bit verbose = 1'b1;

  // Reference model: history of samples accepted since arm plus capture window bookkeeping.
  int                m_state = 0;
  logic [DATA_W-1:0] hist[$];
  int                m_first = 0, m_total = 0, m_pushed = 0;
  bit                m_trig = 0, m_ovf = 0, m_prev = 0, m_push = 0, m_di_chk = 0;
  logic [DATA_W-1:0] m_di = '0;
  logic [DATA_W-1:0] got_q[$];
  int                sidx = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    int k;
    bit m, fire, do_push;
    if (!rst) begin
      m_state = 0; m_push = 0; m_di = '0; m_di_chk = 1;
      m_trig = 0; m_ovf = 0; m_prev = 0; hist.delete();
    end else begin
      m_push = 0; m_di_chk = 0;
      if (abort_i) begin
        m_state = 0;
      end else if (m_state == 0 || m_state == 3) begin
        if (arm_i) begin
          m_state = 1; hist.delete(); m_trig = 0; m_ovf = 0; m_prev = 0; m_pushed = 0;
        end
      end else if (sample_en_i) begin
        k = hist.size();
        hist.push_back(data_i);
        do_push = (m_state == 2);
        if (m_state == 1) begin
          m = (((trig_i ^ trig_pattern_i) & trig_mask_i) == '0);
          fire = (k >= PRE_DEPTH) && (force_trig_i || (trig_edge_i ? (m && !m_prev) : m));
          m_prev = m;
          if (fire) begin
            m_trig = 1; m_first = k - PRE_DEPTH;
            m_total = PRE_DEPTH + 1 + int'(capture_len_i);
            m_pushed = 0; m_state = 2; do_push = 1;
          end
        end
        if (do_push) begin
          if (fifo_full_i) begin
            m_ovf = 1; m_state = 3;
          end else begin
            m_push = 1; m_di = hist[m_first + m_pushed]; m_pushed++;
            if (m_pushed == m_total) m_state = 3;
          end
        end
      end
    end
  endtask

  // One clock: advance model at the edge, compare all outputs 1 time unit later.
  task automatic cyc();
    @(posedge wclk);
    model_edge();
    #1;
    chk("push", PUSH_o, m_push);
    if (m_push || m_di_chk) chk("di", DI_o, m_di);
    chk("state", state_o, m_state);
    chk("busy", busy_o, (m_state == 1 || m_state == 2));
    chk("done", done_o, (m_state == 3));
    chk("triggered", triggered_o, m_trig);
    chk("overflow", overflow_o, m_ovf);
    if (PUSH_o) begin
      got_q.push_back(DI_o);
      if (verbose) $display("push word %0h", DI_o);
    end
  endtask

  task automatic arm_now();
    got_q.delete();
    arm_i = 1; sample_en_i = 0;
    cyc();
    arm_i = 0; sidx = 0;
  endtask

  initial begin
    // Reset and literal reset state
    rst = 0; cyc(); cyc();
    chk("rst_state", state_o, 0);
    chk("rst_push", PUSH_o, 0);
    chk("rst_di", DI_o, 0);
    rst = 1;

    // 1: level trigger at sample 10, len 3 -> words 6..13
    trig_mask_i = 8'hFF; trig_pattern_i = 8'h5A; trig_edge_i = 0; capture_len_i = 3;
    arm_now();
    for (int s = 0; s < 20; s++) begin
      data_i = DATA_W'(s); trig_i = (s == 10) ? 8'h5A : 8'h00; sample_en_i = 1; cyc();
    end
    sample_en_i = 0;
    chk("t1_count", got_q.size(), 8);
    for (int i = 0; i < 8 && i < got_q.size(); i++) chk("t1_word", got_q[i], 6 + i);
    chk("t1_done", done_o, 1); chk("t1_trig", triggered_o, 1); chk("t1_ovf", overflow_o, 0);
    $display("test1 level trigger: %0d pushes", got_q.size());

    // 2: mask 0 -> fires on 5th sample, first word is sample 0
    trig_mask_i = 8'h00;
    arm_now();
    for (int s = 0; s < 16; s++) begin
      data_i = DATA_W'(s); trig_i = 8'h00; sample_en_i = 1; cyc();
    end
    sample_en_i = 0;
    chk("t2_count", got_q.size(), 8);
    if (got_q.size() > 0) chk("t2_first", got_q[0], 0);
    $display("test2 mask zero: %0d pushes", got_q.size());

    // 3: edge mode; match held from arm never fires, re-raise at 20 fires
    trig_mask_i = 8'hFF; trig_edge_i = 1; capture_len_i = 2;
    arm_now();
    for (int s = 0; s < 30; s++) begin
      data_i = DATA_W'(s); trig_i = (s == 19) ? 8'h00 : 8'h5A; sample_en_i = 1; cyc();
      if (s == 19) chk("t3_no_early_trig", triggered_o, 0);
    end
    sample_en_i = 0;
    chk("t3_count", got_q.size(), 7);
    for (int i = 0; i < 7 && i < got_q.size(); i++) chk("t3_word", got_q[i], 16 + i);
    $display("test3 edge trigger: %0d pushes", got_q.size());

    // 4: FIFO full after 3rd push truncates capture
    trig_mask_i = 8'h00; trig_edge_i = 0; capture_len_i = 10;
    arm_now();
    for (int s = 0; s < 20; s++) begin
      fifo_full_i = (got_q.size() >= 3);
      data_i = DATA_W'(s); sample_en_i = 1; cyc();
    end
    fifo_full_i = 0; sample_en_i = 0;
    chk("t4_count", got_q.size(), 3);
    chk("t4_ovf", overflow_o, 1); chk("t4_state", state_o, 3);
    $display("test4 fifo full: %0d pushes", got_q.size());

    // 5: sample_en toggling during capture keeps order, one push per enabled cycle
    trig_mask_i = 8'hFF; capture_len_i = 4;
    arm_now();
    for (int c = 0; c < 40; c++) begin
      sample_en_i = (c < 6) ? 1'b1 : c[0];
      if (sample_en_i) begin
        data_i = DATA_W'(sidx); trig_i = (sidx == 5) ? 8'h5A : 8'h00; sidx++;
      end else begin
        data_i = 40'hDEAD; trig_i = 8'h5A;
      end
      cyc();
    end
    sample_en_i = 0;
    chk("t5_count", got_q.size(), 9);
    for (int i = 0; i < 9 && i < got_q.size(); i++) chk("t5_word", got_q[i], 1 + i);
    $display("test5 gated sampling: %0d pushes", got_q.size());

    // 6: abort with arm in CAPTURE, then reset mid-capture
    trig_mask_i = 8'h00; capture_len_i = 10;
    arm_now();
    for (int s = 0; s < 7; s++) begin data_i = DATA_W'(s); sample_en_i = 1; cyc(); end
    abort_i = 1; arm_i = 1; cyc(); abort_i = 0; arm_i = 0;
    chk("t6_abort_state", state_o, 0); chk("t6_abort_push", PUSH_o, 0);
    for (int s = 0; s < 5; s++) cyc();
    chk("t6_abort_count", got_q.size(), 3);
    arm_now();
    for (int s = 0; s < 7; s++) begin data_i = DATA_W'(s); sample_en_i = 1; cyc(); end
    rst = 0; cyc();
    chk("t6_rst_push", PUSH_o, 0); chk("t6_rst_di", DI_o, 0); chk("t6_rst_busy", busy_o, 0);
    chk("t6_rst_trig", triggered_o, 0); chk("t6_rst_state", state_o, 0);
    rst = 1; sample_en_i = 0;
    $display("test6 abort/reset done");

    // Randomized traffic against the model
    verbose = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      rst            = ($urandom_range(0, 499) != 0);
      arm_i          = ($urandom_range(0, 7) == 0);
      abort_i        = ($urandom_range(0, 63) == 0);
      force_trig_i   = ($urandom_range(0, 31) == 0);
      sample_en_i    = ($urandom_range(0, 3) != 0);
      data_i         = {8'($urandom), 32'($urandom)};
      trig_i         = 8'($urandom);
      trig_pattern_i = 8'($urandom);
      case ($urandom_range(0, 4))
        0: trig_mask_i = 8'h00;
        1: trig_mask_i = 8'h01;
        2: trig_mask_i = 8'h03;
        3: trig_mask_i = 8'h0F;
        default: trig_mask_i = 8'hFF;
      endcase
      trig_edge_i    = ($urandom_range(0, 1) == 1);
      capture_len_i  = CNT_W'($urandom_range(0, 12));
      fifo_full_i    = ($urandom_range(0, 15) == 0);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/ila_capture_ctrl.md
# ila_capture_ctrl

Capture controller that sits directly upstream of the width-cascaded ILA sample FIFO, in the sample (write) clock domain. It holds a short pre-trigger delay line and evaluates a masked pattern/edge trigger on the probe bus. After the trigger it drives the FIFO write port (push strobe plus sample word) for a programmed number of samples. It reports capture status to the readout/control logic.

## Interface
- DATA_W, 40, sample word width; equals the FIFO's total data width (slice width × slice count)
- TRIG_W, 8, trigger vector width
- PRE_DEPTH, 4, pre-trigger samples kept in the delay line; must be ≥1
- CNT_W, 15, width of the post-trigger length and push counters
- wclk  in  1  sample clock; the only clock
- rst  in  1  reset, synchronous, active-low
- arm_i  in  1  start a capture: IDLE/DONE → ARMED
- abort_i  in  1  return to IDLE from any state; wins over arm_i
- force_trig_i  in  1  unconditional trigger while ARMED and the delay line is filled
- sample_en_i  in  1  sample qualifier; all data movement happens only on cycles with this high
- data_i  in  DATA_W  probe sample
- trig_i  in  TRIG_W  trigger probe bits
- trig_pattern_i  in  TRIG_W  compare value
- trig_mask_i  in  TRIG_W  1 = bit participates in the compare
- trig_edge_i  in  1  0 = level trigger, 1 = rising-edge-of-match trigger
- capture_len_i  in  CNT_W  post-trigger samples, counted after the trigger sample; sampled on the trigger cycle
- fifo_full_i  in  1  FIFO FULL flag
- PUSH_o  out  1  FIFO push strobe, registered
- DI_o  out  DATA_W  FIFO write data, registered
- busy_o  out  1  state is ARMED or CAPTURE
- triggered_o  out  1  sticky; trigger has fired since the last arm
- done_o  out  1  state is DONE
- overflow_o  out  1  sticky; capture was truncated because the FIFO was full
- state_o  out  2  IDLE=0, ARMED=1, CAPTURE=2, DONE=3

## Operation
- Definitions: match = &(~(trig_i ^ trig_pattern_i) | ~trig_mask_i). match_prev = match registered on sample_en_i cycles.
- Trigger event: a cycle with sample_en_i=1 in ARMED where fill ≥ PRE_DEPTH and any of the following holds:
  - force_trig_i=1
  - trig_edge_i=0 and match=1
  - trig_edge_i=1 and match & ~match_prev
- Delay line d[0..PRE_DEPTH-1]: on each sample_en_i cycle, data_i shifts into d[0] and d[PRE_DEPTH-1] is the outgoing sample. It runs in every state except IDLE.
- fill: saturating count of sample_en_i cycles since arm, capped at PRE_DEPTH.
- IDLE: PUSH_o=0. arm_i → ARMED, which clears fill, match_prev, triggered_o, overflow_o and the push counter.
- ARMED: update fill and match_prev. Trigger event → CAPTURE, set triggered_o, latch target = PRE_DEPTH + 1 + capture_len_i, and make the first push in the same edge.
- CAPTURE: each sample_en_i cycle pushes (PUSH_o=1, DI_o=d[PRE_DEPTH-1]) and increments the push counter. When the counter reaches target → DONE.
- FIFO full: if fifo_full_i=1 on a cycle that would push, suppress the push, set overflow_o, and go → DONE.
- DONE: PUSH_o=0. arm_i starts a new capture. Readout owns the FIFO contents.
- abort_i: → IDLE at the next edge. PUSH_o=0 that edge; flags are held until the next arm.
- Pushed sequence is samples T-PRE_DEPTH … T+capture_len_i in order, where T is the trigger sample.
- Counter widths: CNT_W+1 internally. target is computed without wrap.

## Timing
- Reset (rst=0 at an edge) forces: state IDLE, PUSH_o=0, DI_o=0, busy_o=0, triggered_o=0, done_o=0, overflow_o=0, state_o=0, fill=0, match_prev=0, delay line=0. Reset during CAPTURE terminates with no further push.
- Trigger at edge E (sample T): PUSH_o=1 during cycle E+1 with DI_o = sample T-PRE_DEPTH.
- PUSH_o is a single-cycle strobe per sample_en_i cycle. It is never asserted when fifo_full_i was 1 at the deciding edge.
- state_o, busy_o and done_o change on the same edge as the state.
- The last push and the CAPTURE→DONE transition happen on the same edge.
- arm_i in ARMED or CAPTURE is ignored.
- Edge mode: a match already high when fill saturates does not fire.

## Test plan
- Level trigger, PRE_DEPTH=4, mask=0xFF, pattern=0x5A, data_i=counter, capture_len_i=3, trig_i=0x5A at sample 10 → 8 pushes of data 6..13, then done_o=1, triggered_o=1, overflow_o=0.
- Mask=0x00, level mode → trigger on the first sample with fill=4, i.e. the 5th sample after arm. The first pushed word is sample 0 after arm.
- Edge mode with trig_i held at the pattern from arm → no trigger. Drop and re-raise it at sample 20 → trigger at 20, first push is sample 16.
- fifo_full_i raised after the 3rd push with capture_len_i=10 → exactly 3 pushes, overflow_o=1, state_o=3.
- sample_en_i toggling 1-0-1 during CAPTURE → one push per enabled cycle only, and DI_o order is preserved.
- abort_i together with arm_i in CAPTURE → IDLE, no push after that edge. rst=0 mid-capture → all outputs 0 the next cycle.
